// File: rtl/pcie_board_status.sv
// Board status/indicator controller for the ECP3 Versa PCIe x1 SGDMA demo.
// Synchronises link status, decodes LTSSM and drives LEDs, 7-seg and test points.
module pcie_board_status #(
  parameter int HB_W      = 26,
  parameter int STRETCH_W = 20
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       LED_INV,
  input  logic       FLIP_LANES,
  input  logic [7:0] dip_switch,
  input  logic       pll_lock_i,
  input  logic [3:0] ltssm_i,
  input  logic       dl_up_i,
  input  logic       rx_act_i,
  input  logic       tx_act_i,
  output logic       pll_lk,
  output logic       poll,
  output logic       l0,
  output logic       dl_up,
  output logic       usr0,
  output logic       usr1,
  output logic       usr2,
  output logic       usr3,
  output logic [7:0] led_out,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] TP
);

  localparam logic [3:0] L_POLL = 4'd1;
  localparam logic [3:0] L_L0   = 4'd3;

  localparam logic [HB_W-1:0]      HB_ONE  = {{(HB_W-1){1'b0}}, 1'b1};
  localparam logic [STRETCH_W-1:0] CNT_ONE = {{(STRETCH_W-1){1'b0}}, 1'b1};

  logic [7:0] dip_m, dip_s;
  logic [3:0] ltssm_m, ltssm_s;
  logic       pll_m, pll_s;
  logic       dl_m, dl_s;

  logic [HB_W-1:0] hb;
  logic            hb_bit;

  logic [1:0][STRETCH_W-1:0] act_cnt;
  logic [1:0]                act_tail;
  logic [1:0]                act_on;
  logic [1:0]                strobe;

  logic [3:0] stat_q;
  logic [3:0] usr_q;
  logic [7:0] led_q;
  logic [6:0] seg_q;
  logic       dp_q;
  logic [6:0] tp_q;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    unique case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      dip_m   <= '0;
      dip_s   <= '0;
      ltssm_m <= '0;
      ltssm_s <= '0;
      pll_m   <= 1'b0;
      pll_s   <= 1'b0;
      dl_m    <= 1'b0;
      dl_s    <= 1'b0;
    end else begin
      dip_m   <= dip_switch;
      dip_s   <= dip_m;
      ltssm_m <= ltssm_i;
      ltssm_s <= ltssm_m;
      pll_m   <= pll_lock_i;
      pll_s   <= pll_m;
      dl_m    <= dl_up_i;
      dl_s    <= dl_m;
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      hb <= '0;
    end else begin
      hb <= hb + HB_ONE;
    end
  end

  assign hb_bit = hb[HB_W-1];
  assign strobe = {tx_act_i, rx_act_i};

  // The tail bit adds one cycle after the count hits zero,
  // so a single strobe keeps the indicator up for 2^STRETCH_W cycles.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      act_cnt  <= '0;
      act_tail <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (strobe[i]) begin
          act_cnt[i]  <= '1;
          act_tail[i] <= 1'b0;
        end else begin
          act_tail[i] <= (act_cnt[i] == CNT_ONE);
          if (act_cnt[i] != '0) begin
            act_cnt[i] <= act_cnt[i] - CNT_ONE;
          end
        end
      end
    end
  end

  always_comb begin
    act_on = '0;
    for (int i = 0; i < 2; i++) begin
      act_on[i] = (act_cnt[i] != '0) | act_tail[i];
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
      usr_q  <= '0;
      led_q  <= '0;
      seg_q  <= '0;
      dp_q   <= 1'b0;
      tp_q   <= '0;
    end else begin
      stat_q <= {pll_s,
                 ltssm_s == L_POLL,
                 ltssm_s == L_L0,
                 dl_s};
      usr_q  <= {act_on[1],
                 act_on[0],
                 dl_s & ~hb_bit,
                 hb_bit};
      led_q  <= dl_s ? {act_on[0], act_on[1],
                        hb_bit, 1'b1, ltssm_s}
                     : dip_s;
      seg_q  <= hex7(dip_s[7] ? dip_s[3:0]
                              : ltssm_s);
      dp_q   <= hb_bit;
      tp_q   <= {ltssm_s, dl_s, pll_s, hb_bit};
    end
  end

  // Polarity is applied after the registers so reset reads as "all off".
  assign {pll_lk, poll, l0, dl_up} = stat_q ^ {4{LED_INV}};
  assign {usr3, usr2, usr1, usr0}  = usr_q ^ {4{LED_INV}};
  assign led_out = led_q ^ {8{LED_INV}};
  assign seg     = seg_q ^ {7{LED_INV}};
  assign dp      = dp_q ^ LED_INV;
  assign TP      = {tp_q, FLIP_LANES};

endmodule

// File: tb/tb_pcie_board_status.sv
// Self-checking bench for pcie_board_status.
// Cycle model pushes expected outputs per edge; compared on the falling edge.
module tb_pcie_board_status;

  localparam int HB_W = 4;
  localparam int SW   = 3;
  localparam int SPAN = 1 << SW;

  logic       clk_100 = 1'b0;
  logic       rst;
  logic       LED_INV, FLIP_LANES;
  logic [7:0] dip_switch;
  logic       pll_lock_i;
  logic [3:0] ltssm_i;
  logic       dl_up_i, rx_act_i, tx_act_i;
  logic       pll_lk, poll, l0, dl_up;
  logic       usr0, usr1, usr2, usr3;
  logic [7:0] led_out;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] TP;

  always #5 clk_100 = ~clk_100;

  pcie_board_status #(.HB_W(HB_W), .STRETCH_W(SW)) dut (
    .clk_100(clk_100), .rst(rst),
    .LED_INV(LED_INV), .FLIP_LANES(FLIP_LANES),
    .dip_switch(dip_switch), .pll_lock_i(pll_lock_i),
    .ltssm_i(ltssm_i), .dl_up_i(dl_up_i),
    .rx_act_i(rx_act_i), .tx_act_i(tx_act_i),
    .pll_lk(pll_lk), .poll(poll), .l0(l0), .dl_up(dl_up),
    .usr0(usr0), .usr1(usr1), .usr2(usr2), .usr3(usr3),
    .led_out(led_out), .seg(seg), .dp(dp), .TP(TP)
  );

  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] usr;
    logic [7:0] led;
    logic [6:0] seg;
    logic       dp;
    logic [6:0] tp;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t sb[$];
  exp_t cur;

  logic [7:0]      m_dip1, m_dip2;
  logic [3:0]      m_lt1, m_lt2;
  logic            m_pll1, m_pll2, m_dl1, m_dl2;
  logic [HB_W-1:0] m_hb;
  int              since_rx, since_tx;

  always @(posedge clk_100 or posedge rst) begin
    exp_t e;
    logic hbb, rxa, txa;
    if (rst) begin
      m_dip1 = '0; m_dip2 = '0;
      m_lt1 = '0; m_lt2 = '0;
      m_pll1 = 0; m_pll2 = 0;
      m_dl1 = 0; m_dl2 = 0;
      m_hb = '0;
      since_rx = 1000; since_tx = 1000;
      sb.delete();
    end else begin
      hbb = m_hb[HB_W-1];
      rxa = since_rx < SPAN;
      txa = since_tx < SPAN;
      e.stat = {m_pll2, m_lt2 == 4'd1,
                m_lt2 == 4'd3, m_dl2};
      e.usr  = {txa, rxa, m_dl2 & ~hbb, hbb};
      e.led  = m_dl2 ? {rxa, txa, hbb, 1'b1, m_lt2}
                     : m_dip2;
      e.seg  = seg_tab[m_dip2[7] ? m_dip2[3:0] : m_lt2];
      e.dp   = hbb;
      e.tp   = {m_lt2, m_dl2, m_pll2, hbb};
      sb.push_back(e);
      m_dip2 = m_dip1; m_dip1 = dip_switch;
      m_lt2 = m_lt1;   m_lt1 = ltssm_i;
      m_pll2 = m_pll1; m_pll1 = pll_lock_i;
      m_dl2 = m_dl1;   m_dl1 = dl_up_i;
      m_hb = m_hb + 1'b1;
      if (rx_act_i) since_rx = 0;
      else if (since_rx < 1000) since_rx++;
      if (tx_act_i) since_tx = 0;
      else if (since_tx < 1000) since_tx++;
    end
  end

  int rx_hi, tx_hi;

  always @(negedge clk_100) begin
    if (rst) cur = '0;
    else if (sb.size() != 0) cur = sb.pop_front();
    chk("stat", {pll_lk, poll, l0, dl_up},
        cur.stat ^ {4{LED_INV}});
    chk("usr", {usr3, usr2, usr1, usr0},
        cur.usr ^ {4{LED_INV}});
    chk("led", led_out, cur.led ^ {8{LED_INV}});
    chk("seg", seg, cur.seg ^ {7{LED_INV}});
    chk("dp", dp, cur.dp ^ LED_INV);
    chk("tp", TP, {cur.tp, FLIP_LANES});
    if (usr2 ^ LED_INV) rx_hi++;
    if (usr3 ^ LED_INV) tx_hi++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100);
    #2;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  logic [3:0] lt_codes [5] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd9};
  logic [6:0] lt_seg   [5] = '{7'h3F, 7'h06, 7'h4F, 7'h66, 7'h6F};

  initial begin
    int   tog;
    logic prev;
    logic [6:0] pseg;
    rst = 1; LED_INV = 1; FLIP_LANES = 1;
    dip_switch = 8'hEF; pll_lock_i = 0; ltssm_i = 0;
    dl_up_i = 0; rx_act_i = 0; tx_act_i = 0;
    #23;
    chk("rst_tp", TP, 8'h01);
    chk("rst_led", led_out, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_stat", {pll_lk, poll, l0, dl_up}, 4'hF);
    chk("rst_usr", {usr3, usr2, usr1, usr0, dp}, 5'h1F);
    cyc(1);
    rst = 0;
    edges(3);
    chk("rel_led", led_out, 8'h10);
    chk("rel_seg", seg, 7'h0E);
    chk("rel_dl", dl_up, 1'b1);

    cyc(1);
    rst = 1; LED_INV = 0; FLIP_LANES = 0;
    dip_switch = 8'h05;
    cyc(1);
    rst = 0;
    cyc(4);
    tog = 0;
    prev = usr0;
    repeat (32) begin
      @(negedge clk_100);
      #1;
      if (usr0 !== prev) tog++;
      prev = usr0;
      chk("tp1", TP[1], usr0);
    end
    chk("hb_tog", tog, 4);

    for (int i = 0; i < 5; i++) begin
      cyc(1);
      pseg = seg;
      ltssm_i = lt_codes[i];
      edges(2);
      chk("lt_lat", seg, pseg);
      edges(1);
      chk("lt_seg", seg, lt_seg[i]);
      chk("lt_poll", poll, lt_codes[i] == 4'd1);
      chk("lt_l0", l0, lt_codes[i] == 4'd3);
    end

    cyc(1);
    rx_hi = 0;
    rx_act_i = 1; cyc(1); rx_act_i = 0;
    cyc(20);
    chk("rx_one", rx_hi, SPAN);
    rx_hi = 0;
    rx_act_i = 1; cyc(1); rx_act_i = 0;
    cyc(4);
    rx_act_i = 1; cyc(1); rx_act_i = 0;
    cyc(25);
    chk("rx_retrig", rx_hi, 13);
    rx_hi = 0;
    rx_act_i = 1; cyc(1); rx_act_i = 0;
    cyc(6);
    rx_act_i = 1; cyc(1); rx_act_i = 0;
    cyc(25);
    chk("rx_edge", rx_hi, 15);
    rx_hi = 0; tx_hi = 0;
    tx_act_i = 1; cyc(1); tx_act_i = 0;
    cyc(20);
    chk("tx_one", tx_hi, SPAN);
    chk("tx_indep", rx_hi, 0);

    dl_up_i = 1; pll_lock_i = 1; ltssm_i = 4'd3;
    cyc(5);
    chk("dl_led", led_out & 8'hDF, 8'h13);
    chk("dl_up", dl_up, 1'b1);
    chk("pll", pll_lk, 1'b1);
    dl_up_i = 0;
    edges(3);
    chk("dl_drop", led_out, 8'h05);

    cyc(1);
    rx_act_i = 1; cyc(1); rx_act_i = 0;
    cyc(2);
    @(posedge clk_100);
    #3;
    rst = 1;
    #1;
    chk("ar_usr", {usr3, usr2, usr1, usr0}, 4'h0);
    chk("ar_tp", TP, 8'h00);
    chk("ar_led", led_out, 8'h00);
    cyc(1);
    rst = 0;
    rx_hi = 0;
    cyc(20);
    chk("ar_norx", rx_hi, 0);

    cyc(4);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
